// File: rtl/cry_lut_pkg.sv
// Shared types and constants for the CRY lookup-ROM arbiter.
// The ROM buses use [0:7] ordering with bit i carrying weight 2^i.
package cry_lut_pkg;

    localparam int unsigned RomAw   = 8;
    localparam int unsigned RomDw   = 8;
    localparam int unsigned NreqMin = 2;
    localparam int unsigned NreqMax = 8;

    typedef enum logic [1:0] {
        StIdle,
        StFire,
        StFetch
    } state_e;

    // Map a conventional [7:0] index onto the ROM's [0:7] bus, bit i to bit i.
    function automatic logic [0:RomAw-1] to_rom(input logic [RomAw-1:0] v);
        logic [0:RomAw-1] r;
        for (int i = 0; i < RomAw; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic logic [RomDw-1:0] from_rom(input logic [0:RomDw-1] v);
        logic [RomDw-1:0] r;
        for (int i = 0; i < RomDw; i++) r[i] = v[i];
        return r;
    endfunction

endpackage

// File: rtl/cry_lut_arb_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap.
module rr_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IdxW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [NREQ-1:0] win_o,
    output logic [IdxW-1:0] win_idx_o,
    output logic            any_o
);

    logic [IdxW-1:0] idx;
    logic            found;
    int unsigned     pos;

    always_comb begin
        win_o     = '0;
        win_idx_o = '0;
        found     = 1'b0;
        idx       = '0;
        pos       = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            pos = int'(ptr_i) + i;
            if (pos >= NREQ) pos = pos - NREQ;
            idx = IdxW'(pos);
            if (!found && req_i[idx]) begin
                found      = 1'b1;
                win_o[idx] = 1'b1;
                win_idx_o  = idx;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/cry_lut_arb.sv
// Shares one edge-sampled 256x8 CRY lookup ROM among NREQ requesters with
// round-robin arbitration; one lookup per two cycles when requests are back-to-back.
module cry_lut_arb
    import cry_lut_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic              sys_clk,
    input  logic              resetl,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*8-1:0] addr,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   vld,
    output logic [RomDw-1:0]  rdata,
    output logic [0:RomAw-1]  rom_addr,
    output logic              rom_clk,
    input  logic [0:RomDw-1]  rom_z,
    output logic              busy
);

    localparam int unsigned IdxW = $clog2(NREQ);

    state_e             state_q;
    logic [NREQ-1:0]    gnt_q, vld_q;
    logic [RomDw-1:0]   rdata_q;
    logic [0:RomAw-1]   rom_addr_q;
    logic               rom_clk_q, busy_q;
    logic [IdxW-1:0]    owner_q, ptr_q;

    logic [NREQ-1:0]    win;
    logic [IdxW-1:0]    win_idx;
    logic               any;
    logic [RomAw-1:0]   win_addr;
    logic               arb;

    rr_pick #(
        .NREQ (NREQ),
        .IdxW (IdxW)
    ) u_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .win_o     (win),
        .win_idx_o (win_idx),
        .any_o     (any)
    );

    always_comb begin
        win_addr = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (win_idx == IdxW'(k)) win_addr = addr[k*8 +: 8];
        end
    end

    // Requests are only looked at in IDLE and FETCH, so rom_clk always gets a low cycle first.
    assign arb = any && (state_q == StIdle || state_q == StFetch);

    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            state_q    <= StIdle;
            gnt_q      <= '0;
            vld_q      <= '0;
            rdata_q    <= '0;
            rom_addr_q <= '0;
            rom_clk_q  <= 1'b0;
            busy_q     <= 1'b0;
            owner_q    <= '0;
            ptr_q      <= '0;
        end else begin
            gnt_q     <= '0;
            vld_q     <= '0;
            rom_clk_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                StFire: begin
                    state_q <= StFetch;
                    busy_q  <= 1'b1;
                end
                StFetch: begin
                    rdata_q <= from_rom(rom_z);
                    vld_q   <= NREQ'(1) << owner_q;
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
            if (arb) begin
                rom_addr_q <= to_rom(win_addr);
                rom_clk_q  <= 1'b1;
                gnt_q      <= win;
                owner_q    <= win_idx;
                ptr_q      <= (win_idx == IdxW'(NREQ - 1)) ? '0 : win_idx + IdxW'(1);
                state_q    <= StFire;
                busy_q     <= 1'b1;
            end
        end
    end

    assign gnt      = gnt_q;
    assign vld      = vld_q;
    assign rdata    = rdata_q;
    assign rom_addr = rom_addr_q;
    assign rom_clk  = rom_clk_q;
    assign busy     = busy_q;

endmodule
